// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared widths, FSM state codes and trigger mode codes for the logic analyser capture block
package la_pkg;

    localparam int LA_ADDR_W  = 17;
    localparam int LA_DEPTH_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } la_state_e;

    // Codes 6 and 7 fall through to immediate in the trigger detector.
    localparam logic [2:0] TM_IMMEDIATE = 3'd0;
    localparam logic [2:0] TM_RISING    = 3'd1;
    localparam logic [2:0] TM_FALLING   = 3'd2;
    localparam logic [2:0] TM_HIGH      = 3'd3;
    localparam logic [2:0] TM_LOW       = 3'd4;
    localparam logic [2:0] TM_ANY_EDGE  = 3'd5;

endpackage

// File: rtl/la_trig_detect.sv
// rtl/la_trig_detect.sv - per-strobe trigger condition on one probe bit, tracking the previous strobed value
module la_trig_detect
    import la_pkg::*;
(
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       data_bit,
    input  logic       strobe,
    input  logic [2:0] mode,
    input  logic       clear,
    output logic       hit
);

    logic prev;
    logic prev_valid;
    logic cond;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 1'b0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev       <= 1'b0;
            prev_valid <= 1'b0;
        end else if (strobe) begin
            prev       <= data_bit;
            prev_valid <= 1'b1;
        end
    end

    // Edge modes stay quiet until a first sample has been seen since arm.
    always_comb begin
        cond = 1'b1;
        case (mode)
            TM_RISING:   cond = prev_valid && !prev && data_bit;
            TM_FALLING:  cond = prev_valid && prev && !data_bit;
            TM_HIGH:     cond = data_bit;
            TM_LOW:      cond = !data_bit;
            TM_ANY_EDGE: cond = prev_valid && (prev != data_bit);
            default:     cond = 1'b1;
        endcase
    end

    assign hit = strobe && cond;

endmodule

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - capture sequencer: pre-trigger fill, trigger wait, post-trigger fill, address bookkeeping
module la_capture_ctrl
    import la_pkg::*;
(
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [2:0]            trig_mode,
    input  logic [2:0]            trig_ch,
    input  logic [LA_DEPTH_W-1:0] pre_depth,
    input  logic [LA_DEPTH_W-1:0] post_depth,
    input  logic [7:0]            pmod_data_in,
    input  logic                  sample_en,
    input  logic [LA_ADDR_W-1:0]  wr_addr,
    output logic                  act,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [LA_ADDR_W-1:0]  trig_addr,
    output logic [LA_ADDR_W-1:0]  start_addr,
    output logic [2:0]            state
);

    la_state_e             state_q, state_d;
    logic [2:0]            mode_q, ch_q;
    logic [LA_DEPTH_W-1:0] pre_q, post_q, pre_cnt, post_cnt;
    logic [LA_ADDR_W-1:0]  trig_addr_q, start_addr_q;
    logic                  triggered_q, done_q;
    logic                  in_capture, arm_ok, abort_ok, strobe, hit;
    logic                  pre_inc, post_inc, trig_fire;

    assign in_capture = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    assign arm_ok     = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort_ok   = abort && (state_q != ST_IDLE);
    assign strobe     = sample_en && in_capture;

    la_trig_detect u_trig (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .data_bit (pmod_data_in[ch_q]),
        .strobe   (strobe),
        .mode     (mode_q),
        .clear    (arm_ok),
        .hit      (hit)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pre_inc   = 1'b0;
        post_inc  = 1'b0;
        trig_fire = 1'b0;
        if (abort_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_ok) state_d = (pre_depth != '0) ? ST_PRE : ST_WAIT_TRIG;
                end
                ST_PRE: begin
                    if (sample_en) begin
                        pre_inc = 1'b1;
                        if (pre_cnt + 16'd1 == pre_q) state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (hit) begin
                        trig_fire = 1'b1;
                        state_d   = (post_q == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        post_inc = 1'b1;
                        if (post_cnt + 16'd1 == post_q) state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // pre_cnt holds the strobes actually kept ahead of the trigger, so it is the pre length.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= '0;
            ch_q         <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
            if (abort_ok) begin
                triggered_q <= 1'b0;
            end else if (arm_ok) begin
                mode_q       <= trig_mode;
                ch_q         <= trig_ch;
                pre_q        <= pre_depth;
                post_q       <= post_depth;
                pre_cnt      <= '0;
                post_cnt     <= '0;
                trig_addr_q  <= '0;
                start_addr_q <= '0;
                triggered_q  <= 1'b0;
            end else begin
                if (pre_inc)  pre_cnt  <= pre_cnt + 16'd1;
                if (post_inc) post_cnt <= post_cnt + 16'd1;
                if (trig_fire) begin
                    trig_addr_q  <= wr_addr;
                    start_addr_q <= wr_addr - {1'b0, pre_cnt};
                    triggered_q  <= 1'b1;
                end
            end
        end
    end

    assign act        = in_capture;
    assign busy       = in_capture;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign state      = state_q;

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 SHALL have one clock and one reset: clk_50M, a single clock; rst_n, asynchronous active-low reset.
REQ-002 SHALL have ports:
- clk_50M  in  1  system clock
- rst_n  in  1  async active-low reset
- arm  in  1  start-capture pulse
- abort  in  1  cancel-capture pulse
- trig_mode  in  3  0 immediate, 1 rising, 2 falling, 3 high, 4 low, 5 any-edge, 6-7 treated as immediate
- trig_ch  in  3  index of the trigger bit in pmod_data_in
- pre_depth  in  16  samples kept before the trigger
- post_depth  in  16  samples kept after the trigger sample
- pmod_data_in  in  8  live probe inputs
- sample_en  in  1  sampler write strobe, one cycle per stored sample
- wr_addr  in  17  sampler write address for the current sample_en
- act  out  1  sampler enable
- busy  out  1  high in PRE, WAIT_TRIG and POST
- triggered  out  1  trigger seen in the current or last capture
- done  out  1  one-cycle completion pulse
- trig_addr  out  17  wr_addr of the trigger sample
- start_addr  out  17  (trig_addr - pre_len) mod 2^17, oldest valid sample
- state  out  3  FSM state code, for debug

Function
REQ-003 SHALL latch trig_mode, trig_ch, pre_depth and post_depth on an accepted arm; later input changes SHALL NOT affect the running capture.
REQ-004 FSM states SHALL be IDLE, PRE, WAIT_TRIG, POST and DONE.
REQ-005 Transitions:
- arm in IDLE or DONE: go to PRE if pre_depth != 0, otherwise go to WAIT_TRIG.
- arm in any other state: ignored.
REQ-006 PRE: count sample_en strobes; on the strobe that brings the count to pre_depth, go to WAIT_TRIG. No trigger evaluation in PRE.
REQ-007 WAIT_TRIG: evaluate the trigger only on sample_en cycles, using bit b = pmod_data_in[trig_ch] and prev (b at the previous strobe).
- immediate, high, low: condition true, b==1, b==0 respectively.
- rising: prev==0 and b==1; falling: prev==1 and b==0; any-edge: prev!=b.
- Edge modes SHALL require prev_valid.
REQ-008 prev and prev_valid SHALL update on every sample_en in PRE, WAIT_TRIG and POST; prev_valid SHALL clear on an accepted arm.
REQ-009 On the trigger strobe: capture trig_addr=wr_addr and set triggered, both visible the next cycle; go to POST, or go directly to DONE if post_depth==0.
REQ-010 POST: count sample_en strobes, excluding the trigger sample; on the post_depth-th strobe, go to DONE.
REQ-011 Entry to DONE SHALL pulse done for exactly one cycle, in the first DONE cycle. DONE SHALL hold trig_addr, start_addr and triggered until the next accepted arm.
REQ-012 pre_len SHALL equal the PRE strobes actually counted, or pre_depth.
REQ-013 start_addr SHALL be computed with a 17-bit modulo subtraction; wrap below 0 is required.
REQ-014 Worst-case stored span is pre_depth+post_depth+1 <= 131071 samples, so the circular buffer SHALL never overwrite a kept sample.
REQ-015 act SHALL be high in PRE, WAIT_TRIG and POST, and low in IDLE and DONE.
- act SHALL rise the cycle after the accepted arm.
- act SHALL fall in the same cycle state becomes DONE.
REQ-016 abort in any non-IDLE state SHALL force IDLE on the next cycle: act low, done not pulsed, triggered cleared. Abort in IDLE SHALL do nothing.
REQ-017 If arm and abort are asserted in the same cycle, abort SHALL win.
REQ-018 sample_en arriving while in IDLE or DONE SHALL be ignored.
REQ-019 An accepted arm SHALL clear triggered, trig_addr, start_addr and all counters.

Reset
REQ-020 While rst_n=0: state=IDLE; act=0, busy=0, triggered=0, done=0, trig_addr=0, start_addr=0; counters, prev and prev_valid = 0.
REQ-021 Reset asserted mid-capture SHALL abandon the capture with no done pulse.

Structure
REQ-022 Shared package la_pkg SHALL hold:
- state encodings: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4
- trig_mode codes
- LA_ADDR_W=17 and LA_DEPTH_W=16
REQ-023 Trigger evaluation (REQ-007/008) SHALL be one sub-module, la_trig_detect: inputs bit, strobe, mode, clear; output hit.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- Immediate: mode=0, pre=0, post=3, strobes at wr_addr 10,11,12,13 -> trig_addr=10, start_addr=10, done one cycle after the addr-13 strobe, act then 0.
- Rising with pre: mode=1, ch=2, pre=4, post=2, bit2 = 0 for 6 strobes then 1 at wr_addr 0x00020 -> trig_addr=0x00020, start_addr=0x0001C, no trigger accepted during PRE.
- Wrap: pre=5, trigger at wr_addr=2 -> start_addr=0x1FFFD.
- Abort: abort in POST -> IDLE next cycle, act=0, triggered=0, no done pulse.
- Arm+abort same cycle from IDLE -> stays IDLE, act stays 0.
- post_depth=0, mode=3: first strobe with bit high at 0x00100 -> DONE next cycle, trig_addr=0x00100, and a new arm from DONE restarts a capture.
